// File: rtl/number_game_defs.sv
// Shared constants, state encoding and timing helper for the number game.
package number_game_defs;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_e;

  localparam int DEF_NUM_W         = 10;
  localparam int DEF_SCORE_W       = 7;
  localparam int DEF_MAX_SCORE     = 99;
  localparam int DEF_TICKS_PER_SEC = 50000000;
  localparam int DEF_START_TIME    = 10;
  localparam int DEF_MIN_TIME      = 3;
  localparam int DEF_LEVEL_STEP    = 5;
  localparam int DEF_LIVES         = 3;
  localparam int DEF_MODE          = 0;

  // Round length shrinks by one second per level down to a floor.
  function automatic logic [4:0] round_time(
    input logic [3:0] lvl,
    input int         start_t,
    input int         min_t
  );
    int t;
    t = start_t - int'(lvl);
    if (t < min_t) t = min_t;
    return 5'(t);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Divides the system clock down to a one-cycle pulse per second.
module tick_gen
  import number_game_defs::*;
#(
  parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/number_game_ctrl.sv
// Game controller: target tracking, scoring, lives, levels and round timer.
module number_game_ctrl
  import number_game_defs::*;
#(
  parameter int NUM_W         = DEF_NUM_W,
  parameter int SCORE_W       = DEF_SCORE_W,
  parameter int MAX_SCORE     = DEF_MAX_SCORE,
  parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
  parameter int START_TIME    = DEF_START_TIME,
  parameter int MIN_TIME      = DEF_MIN_TIME,
  parameter int LEVEL_STEP    = DEF_LEVEL_STEP,
  parameter int LIVES         = DEF_LIVES,
  parameter int MODE          = DEF_MODE
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [NUM_W-1:0]   guess,
  input  logic [NUM_W-1:0]   random,
  input  logic               submit,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [NUM_W-1:0]   number,
  output logic [4:0]         time_left,
  output logic [1:0]         lives,
  output logic [3:0]         level,
  output logic               hit,
  output logic               miss,
  output logic               win
);

  localparam int  SW       = $clog2(LEVEL_STEP + 1);
  localparam bit  SUBMIT_M = (MODE == 1);

  state_e             state_q;
  logic [SCORE_W-1:0] score_q;
  logic [NUM_W-1:0]   number_q;
  logic [4:0]         time_q;
  logic [1:0]         lives_q;
  logic [3:0]         level_q, level_d;
  logic [SW-1:0]      step_q, step_d;
  logic               hit_q, miss_q, win_q;

  logic in_play, match, hit_now, sub_miss;
  logic tick, tmo, lose_ev, lvl_up;

  assign in_play  = (state_q == S_PLAY);
  assign match    = (guess == number_q);
  assign hit_now  = in_play && (SUBMIT_M ? (submit && match) : match);
  assign sub_miss = in_play && SUBMIT_M && submit && !match;
  // A hit on the expiring tick wins over the timeout.
  assign tmo      = in_play && tick && (time_q == 5'd1) && !hit_now;
  assign lose_ev  = sub_miss || tmo;

  assign lvl_up  = (step_q == SW'(LEVEL_STEP - 1));
  assign step_d  = lvl_up ? '0 : step_q + 1'b1;
  assign level_d = (lvl_up && level_q != 4'hF) ? level_q + 4'd1 : level_q;

  tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_tick (
    .clk_i  (clock),
    .rst_i  (reset),
    .en_i   (in_play),
    .clear_i(!in_play || hit_now),
    .tick_o (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      score_q  <= '0;
      number_q <= '0;
      time_q   <= '0;
      lives_q  <= 2'(LIVES);
      level_q  <= '0;
      step_q   <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      win_q    <= 1'b0;
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_OVER: begin
          if (start) begin
            state_q  <= S_PLAY;
            number_q <= random;
            score_q  <= '0;
            lives_q  <= 2'(LIVES);
            level_q  <= '0;
            step_q   <= '0;
            win_q    <= 1'b0;
            time_q   <= 5'(START_TIME);
          end
        end
        S_PLAY: begin
          if (tick && time_q != 5'd0)
            time_q <= time_q - 5'd1;
          if (hit_now) begin
            hit_q    <= 1'b1;
            score_q  <= score_q + 1'b1;
            number_q <= random;
            step_q   <= step_d;
            level_q  <= level_d;
            time_q   <= round_time(level_d, START_TIME, MIN_TIME);
            if (score_q == SCORE_W'(MAX_SCORE - 1)) begin
              state_q <= S_OVER;
              win_q   <= 1'b1;
            end
          end else if (lose_ev) begin
            miss_q <= 1'b1;
            if (tmo) begin
              number_q <= random;
              time_q   <= round_time(level_q, START_TIME, MIN_TIME);
            end
            if (lives_q == 2'd1) begin
              lives_q <= 2'd0;
              time_q  <= 5'd0;
              state_q <= S_OVER;
            end else begin
              lives_q <= lives_q - 2'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign state     = state_q;
  assign score     = score_q;
  assign number    = number_q;
  assign time_left = time_q;
  assign lives     = lives_q;
  assign level     = level_q;
  assign hit       = hit_q;
  assign miss      = miss_q;
  assign win       = win_q;

endmodule

// File: tb/tb_number_game_ctrl.sv
// Bench: MODE 0 and MODE 1 instances against a rule-level game model.
module tb_number_game_ctrl;

  localparam int NW   = 6;
  localparam int SCW  = 7;
  localparam int MAXS = 5;
  localparam int TPS  = 4;
  localparam int ST   = 3;
  localparam int MT   = 2;
  localparam int STEP = 2;
  localparam int LIV  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic submit = 1'b0;
  logic [NW-1:0] random = '0;
  logic [NW-1:0] guess0 = '0;
  logic [NW-1:0] guess1 = '0;

  logic [1:0]     st0, st1;
  logic [SCW-1:0] sc0, sc1;
  logic [NW-1:0]  nm0, nm1;
  logic [4:0]     tl0, tl1;
  logic [1:0]     lv0, lv1;
  logic [3:0]     lvl0, lvl1;
  logic           h0, h1, ms0, ms1, w0, w1;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  number_game_ctrl #(
    .NUM_W(NW), .SCORE_W(SCW), .MAX_SCORE(MAXS), .TICKS_PER_SEC(TPS),
    .START_TIME(ST), .MIN_TIME(MT), .LEVEL_STEP(STEP), .LIVES(LIV), .MODE(0)
  ) u_dut0 (
    .clock(clk), .reset(rst), .start(start), .guess(guess0),
    .random(random), .submit(submit), .state(st0), .score(sc0),
    .number(nm0), .time_left(tl0), .lives(lv0), .level(lvl0),
    .hit(h0), .miss(ms0), .win(w0)
  );

  number_game_ctrl #(
    .NUM_W(NW), .SCORE_W(SCW), .MAX_SCORE(MAXS), .TICKS_PER_SEC(TPS),
    .START_TIME(ST), .MIN_TIME(MT), .LEVEL_STEP(STEP), .LIVES(LIV), .MODE(1)
  ) u_dut1 (
    .clock(clk), .reset(rst), .start(start), .guess(guess1),
    .random(random), .submit(submit), .state(st1), .score(sc1),
    .number(nm1), .time_left(tl1), .lives(lv1), .level(lvl1),
    .hit(h1), .miss(ms1), .win(w1)
  );

  // Model: 0=idle 1=play 2=over; level derived from total hits.
  int m_st[2], m_sc[2], m_num[2], m_tl[2], m_lv[2];
  int m_hits[2], m_sub[2], m_h[2], m_ms[2], m_w[2];

  function automatic int mlvl(input int m);
    int l;
    l = m_hits[m] / STEP;
    return (l > 15) ? 15 : l;
  endfunction

  function automatic int rt(input int l);
    return (ST - l < MT) ? MT : ST - l;
  endfunction

  task automatic mreset(input int m);
    m_st[m] = 0; m_sc[m] = 0; m_num[m] = 0; m_tl[m] = 0; m_lv[m] = LIV;
    m_hits[m] = 0; m_sub[m] = 0; m_h[m] = 0; m_ms[m] = 0; m_w[m] = 0;
  endtask

  task automatic mstep(input int m, input int g, input int mode);
    bit eq, ih, sm, se, to;
    m_h[m] = 0;
    m_ms[m] = 0;
    if (m_st[m] != 1) begin
      if (start) begin
        m_st[m] = 1; m_num[m] = int'(random); m_sc[m] = 0; m_lv[m] = LIV;
        m_hits[m] = 0; m_w[m] = 0; m_tl[m] = ST; m_sub[m] = 0;
      end
    end else begin
      eq = (g == m_num[m]);
      ih = (mode == 0) ? eq : (submit && eq);
      sm = (mode == 1) && submit && !eq;
      se = (m_sub[m] == TPS - 1);
      m_sub[m] = (m_sub[m] + 1) % TPS;
      if (ih) begin
        m_h[m] = 1; m_sc[m]++; m_hits[m]++;
        m_num[m] = int'(random); m_tl[m] = rt(mlvl(m)); m_sub[m] = 0;
        if (m_sc[m] == MAXS) begin m_st[m] = 2; m_w[m] = 1; end
      end else begin
        to = se && (m_tl[m] == 1);
        if (se && m_tl[m] > 0) m_tl[m]--;
        if (to || sm) begin
          m_ms[m] = 1;
          if (to) begin m_num[m] = int'(random); m_tl[m] = rt(mlvl(m)); end
          m_lv[m]--;
          if (m_lv[m] == 0) begin m_st[m] = 2; m_tl[m] = 0; end
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mreset(0);
      mreset(1);
    end else begin
      mstep(0, int'(guess0), 0);
      mstep(1, int'(guess1), 1);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int m, input int s, input int sc,
                          input int n, input int t, input int l,
                          input int lv, input int h, input int ms,
                          input int w);
    chk($sformatf("m%0d.state", m), s, m_st[m]);
    chk($sformatf("m%0d.score", m), sc, m_sc[m]);
    chk($sformatf("m%0d.number", m), n, m_num[m]);
    chk($sformatf("m%0d.time_left", m), t, m_tl[m]);
    chk($sformatf("m%0d.lives", m), l, m_lv[m]);
    chk($sformatf("m%0d.level", m), lv, mlvl(m));
    chk($sformatf("m%0d.hit", m), h, m_h[m]);
    chk($sformatf("m%0d.miss", m), ms, m_ms[m]);
    chk($sformatf("m%0d.win", m), w, m_w[m]);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_inst(0, int'(st0), int'(sc0), int'(nm0), int'(tl0), int'(lv0),
               int'(lvl0), int'(h0), int'(ms0), int'(w0));
      cmp_inst(1, int'(st1), int'(sc1), int'(nm1), int'(tl1), int'(lv1),
               int'(lvl1), int'(h1), int'(ms1), int'(w1));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    step();
    chk("rst.state", int'(st0), 0);
    chk("rst.score", int'(sc0), 0);
    chk("rst.number", int'(nm0), 0);
    chk("rst.time", int'(tl0), 0);
    chk("rst.lives", int'(lv0), 2);
    chk("rst.level", int'(lvl0), 0);
    chk("rst.pulses", int'({h0, ms0, w0}), 0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // First hit with the guess held on the target
    start = 1'b1; random = 6'd37; guess0 = 6'd37;
    step();
    start = 1'b0; random = 6'd20;
    chk("play.state", int'(st0), 1);
    chk("play.number", int'(nm0), 37);
    chk("play.time", int'(tl0), 3);
    step();
    chk("hit1.hit", int'(h0), 1);
    chk("hit1.score", int'(sc0), 1);
    chk("hit1.number", int'(nm0), 20);

    // Timeouts until game over
    random = 6'd5; guess0 = 6'd60;
    for (int i = 0; i < 11; i++) step();
    chk("to.time1", int'(tl0), 1);
    chk("to.lives_pre", int'(lv0), 2);
    step();
    chk("to.miss", int'(ms0), 1);
    chk("to.lives", int'(lv0), 1);
    chk("to.reload", int'(tl0), 3);
    for (int i = 0; i < 12; i++) step();
    chk("over.state", int'(st0), 2);
    chk("over.win", int'(w0), 0);
    chk("over.lives", int'(lv0), 0);
    chk("over.time", int'(tl0), 0);

    // Level progression and time floor
    start = 1'b1; random = 6'd10;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      guess0 = 6'(10 + i);
      random = 6'(11 + i);
      step();
      if (i == 1) begin
        chk("lvl1.level", int'(lvl0), 1);
        chk("lvl1.time", int'(tl0), 2);
      end
    end
    chk("lvl2.score", int'(sc0), 4);
    chk("lvl2.level", int'(lvl0), 2);
    chk("lvl2.time", int'(tl0), 2);

    // Hit on the expiring tick, which is also the winning hit
    guess0 = 6'd0; random = 6'd3;
    for (int i = 0; i < 7; i++) step();
    chk("prio.time1", int'(tl0), 1);
    guess0 = 6'd14;
    step();
    chk("prio.hit", int'(h0), 1);
    chk("prio.miss", int'(ms0), 0);
    chk("prio.lives", int'(lv0), 2);
    chk("win.state", int'(st0), 2);
    chk("win.win", int'(w0), 1);
    chk("win.score", int'(sc0), 5);
    chk("m1.to.miss", int'(ms1), 1);
    chk("m1.to.state", int'(st1), 1);

    // Asynchronous reset between edges
    rst = 1'b1;
    #1;
    chk("arst.state", int'(st1), 0);
    chk("arst.lives", int'(lv1), 2);
    chk("arst.number", int'(nm1), 0);
    chk("arst.time", int'(tl1), 0);
    chk("arst.miss", int'(ms1), 0);
    step();
    rst = 1'b0;

    // Submit mode: wrong then right
    guess0 = 6'd0; start = 1'b1; random = 6'd40;
    step();
    start = 1'b0; guess1 = 6'd7; submit = 1'b1; random = 6'd50;
    step();
    chk("sub.miss", int'(ms1), 1);
    chk("sub.lives", int'(lv1), 1);
    chk("sub.number", int'(nm1), 40);
    guess1 = 6'd40; random = 6'd9;
    step();
    chk("sub.hit", int'(h1), 1);
    chk("sub.score", int'(sc1), 1);
    chk("sub.number2", int'(nm1), 9);
    submit = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 499) == 0);
      start  = ($urandom_range(0, 19) == 0);
      submit = ($urandom_range(0, 2) == 0);
      random = NW'($urandom);
      guess0 = ($urandom_range(0, 2) == 0) ? NW'(m_num[0]) : NW'($urandom);
      guess1 = ($urandom_range(0, 2) == 0) ? NW'(m_num[1]) : NW'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/number_game_ctrl.md
NUMBER_GAME_CTRL -- requirements
Module: number_game_ctrl

Interface
REQ-001 SHALL have parameter NUM_W, default 10, meaning target/guess width.
REQ-002 SHALL have parameter SCORE_W, default 7, meaning score width; MAX_SCORE = 99 (parameter), win threshold.
REQ-003 SHALL have parameter TICKS_PER_SEC, default 50000000, meaning clock cycles per second tick.
REQ-004 SHALL have parameters START_TIME 10, MIN_TIME 3, LEVEL_STEP 5, LIVES 3, MODE 0 (0 = continuous match, 1 = submit-to-check).
REQ-005 SHALL have: clock  in  1  single system clock; all state changes on its rising edge.
REQ-006 SHALL have: reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have: start  in  1  one-cycle pulse, begins new game from IDLE or OVER.
REQ-008 SHALL have: guess  in  NUM_W  player switches; random  in  NUM_W  free-running random source.
REQ-009 SHALL have: submit  in  1  one-cycle pulse, used only when MODE = 1.
REQ-010 SHALL have: state  out  2  IDLE=0, PLAY=1, OVER=2; score  out  SCORE_W; number  out  NUM_W current target.
REQ-011 SHALL have: time_left  out  5  seconds remaining; lives  out  2; level  out  4; hit, miss  out  1  one-cycle pulses; win  out  1.

Function
REQ-012 SHALL, in IDLE or OVER on start, enter PLAY next cycle with number=random, score=0, lives=LIVES, level=0, win=0, time_left=START_TIME, tick counter=0.
REQ-013 SHALL, in PLAY, count ticks 0..TICKS_PER_SEC-1 and decrement time_left by 1 on each wrap.
REQ-014 SHALL define a hit as guess==number (MODE 0) or submit && guess==number (MODE 1).
REQ-015 SHALL, on a hit: score+1, pulse hit, load number=random, reload time_left=round_time(level'), clear tick counter, all in one cycle.
REQ-016 SHALL increment level after every LEVEL_STEP hits, saturating at 15; round_time = max(START_TIME - level, MIN_TIME).
REQ-017 SHALL, in MODE 1, treat submit with guess!=number as a miss: lives-1, pulse miss, number and timer unchanged.
REQ-018 SHALL treat time_left decrementing from 1 to 0 as a timeout: lives-1, pulse miss, new number, time_left reloaded.
REQ-019 SHALL enter OVER, win=0, when a miss or timeout occurs with lives==1; lives then reads 0, time_left 0.
REQ-020 SHALL enter OVER, win=1, when a hit brings score to MAX_SCORE; score never exceeds MAX_SCORE.
REQ-021 SHALL give a hit priority over a timeout in the same cycle (no life lost).
REQ-022 SHALL ignore submit in MODE 0 and ignore guess/submit outside PLAY.
REQ-023 SHALL hold all outputs stable in OVER until start; start in PLAY is ignored.

Reset
REQ-024 SHALL, on reset assertion, immediately force state=IDLE, score=0, number=0, time_left=0, lives=LIVES, level=0, hit=miss=win=0, tick counter=0.
REQ-025 SHALL abort a game in progress on reset with no pulse emitted; first start after release behaves per REQ-012.

Structure
REQ-026 SHALL take state encodings and default parameter values from a shared number_game_defs constants file.
REQ-027 SHALL place second-tick generation in one sub-module, tick_gen (parameter TICKS_PER_SEC, clear input, one-cycle tick output).
REQ-028 SHALL keep display decoding outside this block.

Verification (TICKS_PER_SEC=4, START_TIME=3, MIN_TIME=2, LEVEL_STEP=2, LIVES=2, MAX_SCORE=5)
REQ-029 SHALL check: start with random=37, guess=37 held -> PLAY, next cycle hit pulse, score=1, number=new random.
REQ-030 SHALL check: start, no match for 12 cycles -> time_left 3,2,1,0, miss pulse, lives=1; further 12 cycles -> OVER, win=0.
REQ-031 SHALL check: 2 hits -> level=1, time_left reloads 2; 4 hits -> level=2, time_left still 2 (floor).
REQ-032 SHALL check: MODE=1, submit with guess!=number -> miss, lives 2->1, number unchanged; correct submit -> hit.
REQ-033 SHALL check: hit on the cycle time_left would reach 0 -> hit, lives unchanged; 5 hits -> OVER, win=1, score=5.
REQ-034 SHALL check: reset asserted mid-PLAY between clock edges -> outputs reset values before next edge, state=IDLE.
